// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - fetch-unit bus: PC+4 feedback, hazard/redirect controls, imem request, IF/ID slot
interface pc_fetch_unit_if;
  logic [31:0] PCPlus;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        imem_ready;
  logic [31:0] PC;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic        fault;

  modport master (
    output PCPlus, stall, redirect, redirect_target, imem_ready,
    input  PC, imem_req, imem_addr, ifid_valid, ifid_pc, ifid_pc_plus4, fault
  );

  modport slave (
    input  PCPlus, stall, redirect, redirect_target, imem_ready,
    output PC, imem_req, imem_addr, ifid_valid, ifid_pc, ifid_pc_plus4, fault
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register, fetch FSM and IF/ID slot; optional misaligned-redirect trap under PC_MISALIGN_TRAP_EN
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic             CLK,
  input  logic             RST_N,
  pc_fetch_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_FETCH = 2'b01,
    ST_HOLD  = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_ifid_valid;
  logic [31:0] r_ifid_pc;
  logic [31:0] r_ifid_pc4;

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic        w_ifid_valid_nxt;
  logic [31:0] w_ifid_pc_nxt;
  logic [31:0] w_ifid_pc4_nxt;

`ifndef PC_MISALIGN_TRAP_EN
  // Without the trap, the low two bits of a redirect target are simply dropped.
  logic [31:0] w_target_aligned;
  assign w_target_aligned = bus.redirect_target & ~32'd3;
`endif

  // State, PC and IF/ID registers; reset abandons any outstanding fetch.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= ST_BOOT;
      r_pc         <= RESET_VECTOR;
      r_ifid_valid <= 1'b0;
      r_ifid_pc    <= 32'd0;
      r_ifid_pc4   <= 32'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_ifid_valid <= w_ifid_valid_nxt;
      r_ifid_pc    <= w_ifid_pc_nxt;
      r_ifid_pc4   <= w_ifid_pc4_nxt;
    end
  end

  // Next state and register updates; priority is redirect, then fault hold, then stall, then fetch.
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_ifid_valid_nxt = r_ifid_valid;
    w_ifid_pc_nxt    = r_ifid_pc;
    w_ifid_pc4_nxt   = r_ifid_pc4;
    case (r_state)
      ST_BOOT: begin
        w_state_nxt = ST_FETCH;
      end
      ST_FETCH, ST_HOLD, ST_FAULT: begin
        if (bus.redirect) begin
          w_ifid_valid_nxt = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
          if (bus.redirect_target[1:0] != 2'b00) begin
            w_state_nxt = ST_FAULT;
          end else begin
            w_pc_nxt    = bus.redirect_target;
            w_state_nxt = ST_FETCH;
          end
`else
          w_pc_nxt    = w_target_aligned;
          w_state_nxt = ST_FETCH;
`endif
        end else if (r_state == ST_FAULT) begin
          w_state_nxt = ST_FAULT;
        end else if (bus.stall) begin
          w_state_nxt = ST_HOLD;
        end else if (r_state == ST_HOLD) begin
          w_state_nxt = ST_FETCH;
        end else if (bus.imem_ready) begin
          w_pc_nxt         = bus.PCPlus;
          w_ifid_pc_nxt    = r_pc;
          w_ifid_pc4_nxt   = bus.PCPlus;
          w_ifid_valid_nxt = 1'b1;
        end else begin
          w_ifid_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  assign bus.PC            = r_pc;
  assign bus.imem_addr     = r_pc;
  assign bus.imem_req      = (r_state == ST_FETCH);
  assign bus.ifid_valid    = r_ifid_valid;
  assign bus.ifid_pc       = r_ifid_pc;
  assign bus.ifid_pc_plus4 = r_ifid_pc4;
`ifdef PC_MISALIGN_TRAP_EN
  assign bus.fault         = (r_state == ST_FAULT);
`else
  assign bus.fault         = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;
  logic CLK;
  logic RST_N;
  int   n_total;
  int   n_pass;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  // Downstream PC+4 adder
  assign bus.PCPlus = bus.PC + 32'd4;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    RST_N = 1'b0;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_target = 32'd0;
    bus.imem_ready = 1'b1;
    step();
    step();
    chk("rst_pc", bus.PC, 32'h0);
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_valid", {31'd0, bus.ifid_valid}, 32'd0);
    chk("rst_ifid_pc", bus.ifid_pc, 32'h0);
    chk("rst_ifid_pc4", bus.ifid_pc_plus4, 32'h0);
    chk("rst_fault", {31'd0, bus.fault}, 32'd0);
    RST_N = 1'b1;
    #1;
    chk("boot_req", {31'd0, bus.imem_req}, 32'd0);

    step();
    chk("fetch0_req", {31'd0, bus.imem_req}, 32'd1);
    chk("fetch0_pc", bus.PC, 32'h0);
    chk("fetch0_addr", bus.imem_addr, 32'h0);
    chk("fetch0_valid", {31'd0, bus.ifid_valid}, 32'd0);
    step();
    chk("seq_pc4", bus.PC, 32'h4);
    chk("seq_ifid0", bus.ifid_pc, 32'h0);
    chk("seq_ifid0_p4", bus.ifid_pc_plus4, 32'h4);
    chk("seq_valid", {31'd0, bus.ifid_valid}, 32'd1);
    step();
    chk("seq_pc8", bus.PC, 32'h8);
    chk("seq_ifid4", bus.ifid_pc, 32'h4);
    step();
    chk("seq_pc12", bus.PC, 32'hC);
    chk("seq_ifid8", bus.ifid_pc, 32'h8);
    step();
    chk("seq_pc16", bus.PC, 32'h10);
    chk("seq_ifid12", bus.ifid_pc, 32'hC);

    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", bus.PC, 32'h10);
      chk("stall_ifid_pc", bus.ifid_pc, 32'hC);
      chk("stall_valid", {31'd0, bus.ifid_valid}, 32'd1);
      chk("stall_req", {31'd0, bus.imem_req}, 32'd0);
    end
    bus.stall = 1'b0;
    step();
    chk("resume_req", {31'd0, bus.imem_req}, 32'd1);
    chk("resume_addr", bus.imem_addr, 32'h10);
    chk("resume_ifid_pc", bus.ifid_pc, 32'hC);
    step();
    chk("resume_pc", bus.PC, 32'h14);
    chk("resume_ifid_pc2", bus.ifid_pc, 32'h10);

    bus.stall = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_target = 32'h200;
    step();
    chk("rdst_pc", bus.PC, 32'h200);
    chk("rdst_valid", {31'd0, bus.ifid_valid}, 32'd0);
    chk("rdst_req", {31'd0, bus.imem_req}, 32'd1);
    chk("rdst_addr", bus.imem_addr, 32'h200);
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    step();
    chk("rdst_next_pc", bus.PC, 32'h204);
    chk("rdst_next_ifid", bus.ifid_pc, 32'h200);

    bus.redirect = 1'b1;
    bus.redirect_target = 32'h40;
    step();
    chk("rd40_pc", bus.PC, 32'h40);
    bus.redirect = 1'b0;
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("nrdy_pc", bus.PC, 32'h40);
      chk("nrdy_valid", {31'd0, bus.ifid_valid}, 32'd0);
    end
    bus.imem_ready = 1'b1;
    step();
    chk("rdy_pc", bus.PC, 32'h44);
    chk("rdy_ifid_pc", bus.ifid_pc, 32'h40);
    chk("rdy_valid", {31'd0, bus.ifid_valid}, 32'd1);

    bus.redirect = 1'b1;
    bus.redirect_target = 32'hFFFF_FFFC;
    step();
    chk("wrap_pre_pc", bus.PC, 32'hFFFF_FFFC);
    bus.redirect = 1'b0;
    step();
    chk("wrap_pc", bus.PC, 32'h0);
    chk("wrap_ifid_pc", bus.ifid_pc, 32'hFFFF_FFFC);
    chk("wrap_ifid_pc4", bus.ifid_pc_plus4, 32'h0);

    bus.stall = 1'b1;
    step();
    chk("hold_req", {31'd0, bus.imem_req}, 32'd0);
    bus.redirect = 1'b1;
    bus.redirect_target = 32'h80;
    step();
    chk("hold_rd_pc", bus.PC, 32'h80);
    chk("hold_rd_req", {31'd0, bus.imem_req}, 32'd1);
    chk("hold_rd_valid", {31'd0, bus.ifid_valid}, 32'd0);
    bus.stall = 1'b0;

    bus.redirect_target = 32'h102;
    step();
`ifdef PC_MISALIGN_TRAP_EN
    chk("mis_fault", {31'd0, bus.fault}, 32'd1);
    chk("mis_pc", bus.PC, 32'h80);
    chk("mis_req", {31'd0, bus.imem_req}, 32'd0);
    bus.redirect_target = 32'h100;
    step();
    chk("mis_clr_fault", {31'd0, bus.fault}, 32'd0);
    chk("mis_clr_pc", bus.PC, 32'h100);
    chk("mis_clr_req", {31'd0, bus.imem_req}, 32'd1);
`else
    chk("mis_pc", bus.PC, 32'h100);
    chk("mis_fault", {31'd0, bus.fault}, 32'd0);
    chk("mis_req", {31'd0, bus.imem_req}, 32'd1);
`endif
    bus.redirect = 1'b0;
    step();
    chk("post_mis_pc", bus.PC, 32'h104);
    chk("post_mis_ifid", bus.ifid_pc, 32'h100);

    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_pc", bus.PC, 32'h0);
    chk("arst_valid", {31'd0, bus.ifid_valid}, 32'd0);
    chk("arst_ifid_pc", bus.ifid_pc, 32'h0);
    chk("arst_req", {31'd0, bus.imem_req}, 32'd0);
    bus.redirect = 1'b1;
    bus.redirect_target = 32'h300;
    step();
    RST_N = 1'b1;
    step();
    chk("boot_rd_pc", bus.PC, 32'h0);
    chk("boot_rd_req", {31'd0, bus.imem_req}, 32'd1);
    bus.redirect = 1'b0;
    step();
    chk("boot_rd_next", bus.PC, 32'h4);
    chk("boot_rd_ifid", bus.ifid_pc, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
